switch_allocator: RTL and testbench
===================================

# switch_allocator

Per-cycle switch allocator for the router datapath, sitting directly upstream of the crossbar. Each input port presents one request for a single output port. The allocator arbitrates conflicting requests per output with round-robin priority and gates grants on per-output downstream credit counters. It returns a combinational grant to the input units (buffer pop) and drives registered mapping/valid that the crossbar consumes one cycle later.

## Interface
- `NUM_PORTS`, 4: number of router input and output ports.
- `BUF_DEPTH`, 4: downstream input-buffer depth per output port; initial and maximum credit count.
- `CW`, $clog2(BUF_DEPTH+1): credit counter width (derived localparam, not overridable).

- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input [NUM_PORTS-1:0]: input port i has a flit at the head of its buffer.
- `req_port` input [NUM_PORTS-1:0] x NUM_PORTS (unpacked): one-hot requested output port, per input port.
- `credit_in` input [NUM_PORTS-1:0]: one-cycle pulse, one credit returned by the downstream router on output port o.
- `grant` output [NUM_PORTS-1:0]: combinational; input i won this cycle and must pop its head flit.
- `sa_mapping` output [NUM_PORTS-1:0] x NUM_PORTS (unpacked): registered one-hot output port per input, consumed by the crossbar as its input-to-output mapping.
- `sa_valid` output [NUM_PORTS-1:0]: registered; consumed by the crossbar as its per-input valid.
- `credit_cnt` output CW x NUM_PORTS (unpacked): current credit count per output, for debug and coverage.
- `credit_err` output 1: sticky; set when a credit return would exceed BUF_DEPTH.

## Operation
- Request qualification: input i requests output o iff `req_valid[i]` and `req_port[i]` is exactly one-hot with bit o set. Zero or multi-hot `req_port` counts as no request; that input receives no grant and no state changes.
- Per-output arbiter o considers only qualified requesters for o, and only when `credit_cnt[o] != 0`.
- Round-robin: each output keeps a pointer `rr_ptr[o]` in 0..NUM_PORTS-1. Search starts at `rr_ptr[o]`, ascending and wrapping; the first requester found wins.
- On a grant to input w for output o, `rr_ptr[o]` becomes (w+1) mod NUM_PORTS at the next edge. With no grant, the pointer holds.
- Each input requests a single output, so `grant[i]` is set iff some output picked i. At most one grant per output per cycle.
- Credit counter per output, next value = cnt - grant_o + credit_in[o]:
  - grant and return in the same cycle: net unchanged.
  - return at cnt == BUF_DEPTH: count saturates at BUF_DEPTH and `credit_err` is set.
  - cnt == 0: no grant, so no underflow.
- Registered outputs: `sa_valid[i]` <= `grant[i]`. `sa_mapping[i]` <= `req_port[i]` if granted, else 0.

## Timing
- Reset (asynchronous assert, synchronous release on next edge):
  - `sa_valid` = 0, `sa_mapping` = all zeros.
  - `rr_ptr` = 0 for all outputs.
  - `credit_cnt` = BUF_DEPTH for all outputs.
  - `credit_err` = 0.
- `grant` depends only on current inputs and state; it is 0 whenever `req_valid` is 0 and is valid in the same cycle as the request.
- Latency: request at cycle N gives `grant` at N, and `sa_valid`/`sa_mapping` at N+1 (the crossbar traversal cycle).
- Credit decrement from a grant at N is visible in `credit_cnt` at N+1. A `credit_in` pulse at N is usable for arbitration at N+1.
- Reset mid-operation: all state returns to reset values immediately. In-flight `sa_valid` is dropped and credits are restored to BUF_DEPTH.
- No combinational path from `credit_in` to `grant`.

## Test plan
- Reset, then all four inputs request output 2, held for 4 cycles:
  - grants go to 0, 1, 2, 3 in successive cycles.
  - `sa_valid` and `sa_mapping[i]` = 4'b0100 follow one cycle later.
  - `credit_cnt[2]` goes 4, 3, 2, 1, 0.
- Continue the previous case: `credit_cnt[2]` = 0 with requests held gives no grant. A single `credit_in[2]` pulse gives exactly one grant the next cycle, to input 0 (pointer wrapped).
- Inputs 0..3 request distinct outputs 1, 2, 3, 0 in the same cycle: all four grants asserted; the next cycle `sa_valid` = 4'b1111 with the matching mappings.
- Same-cycle grant on output 1 and `credit_in[1]` with count 2: count stays 2. `credit_in[3]` at count 4: count stays 4 and `credit_err` = 1 until reset.
- `req_port[0]` = 4'b0011 or 4'b0000 with `req_valid[0]` = 1: `grant[0]` = 0; the pointers and credits of all outputs are unchanged.
- Assert `reset_n` low mid-stream with counts at 1: outputs clear asynchronously; after release, counts = 4 and the first contended grant goes to input 0.

Source files
------------

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - round-robin switch allocator with per-output credit gating
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid[i]        input i has a head flit
//   req_port[i]         one-hot requested output of input i
//   credit_in[o]        one credit returned on output o (single-cycle pulse)
//   grant[i]            combinational: input i wins this cycle and pops its head flit
//   sa_mapping[i]       registered one-hot output for input i (crossbar select)
//   sa_valid[i]         registered per-input valid for the crossbar
//   credit_cnt[o]       current downstream credits on output o
//   credit_err          sticky: a credit return would have exceeded BUF_DEPTH

module switch_allocator #(
    parameter int NUM_PORTS = 4,
    parameter int BUF_DEPTH = 4,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_port [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] credit_in,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] sa_mapping [NUM_PORTS],
    output logic [NUM_PORTS-1:0] sa_valid,
    output logic [CW-1:0]        credit_cnt [NUM_PORTS],
    output logic                 credit_err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0]        FULL    = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [PW-1:0]        PTR_ONE = PW'(1);
    localparam logic [PW-1:0]        PTR_MAX = PW'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] VEC_ONE = NUM_PORTS'(1);

    logic [NUM_PORTS-1:0] req_ok;
    logic [NUM_PORTS-1:0] req_mat [NUM_PORTS];  // req_mat[o][i]: input i eligible for output o
    logic [PW-1:0]        rr_ptr  [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_gnt;
    logic [PW-1:0]        out_win [NUM_PORTS];
    logic [NUM_PORTS-1:0] win_oh  [NUM_PORTS];
    logic [CW-1:0]        cnt_next [NUM_PORTS];
    logic [NUM_PORTS-1:0] ovf;

    // A request only counts when its output select is exactly one-hot;
    // zero or multi-hot selects are ignored entirely.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ok[i] = req_valid[i] && (req_port[i] != '0) &&
                        ((req_port[i] & (req_port[i] - VEC_ONE)) == '0);
        end
    end

    // Arbitration looks only at the registered credit count, so credit_in
    // never reaches grant combinationally.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_mat[o][i] = req_ok[i] && req_port[i][o] && (credit_cnt[o] != '0);
            end
        end
    end

    // Per-output round-robin: scan from rr_ptr upward with wrap, first hit wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_gnt[o] = 1'b0;
            out_win[o] = '0;
            win_oh[o]  = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!out_gnt[o] && req_mat[o][idx]) begin
                    out_gnt[o]     = 1'b1;
                    out_win[o]     = PW'(idx);
                    win_oh[o][idx] = 1'b1;
                end
            end
        end
    end

    // Each input asks for one output, so OR-ing the per-output winners
    // can never give an input two grants.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant = grant | win_oh[o];
        end
    end

    // Credit update: a grant and a return in the same cycle cancel; a return
    // with the counter already full saturates and flags an error.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            cnt_next[o] = credit_cnt[o];
            ovf[o]      = 1'b0;
            if (credit_in[o] && !out_gnt[o]) begin
                if (credit_cnt[o] >= FULL) begin
                    ovf[o] = 1'b1;
                end else begin
                    cnt_next[o] = credit_cnt[o] + CNT_ONE;
                end
            end else if (!credit_in[o] && out_gnt[o]) begin
                cnt_next[o] = credit_cnt[o] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                rr_ptr[o]     <= '0;
                credit_cnt[o] <= FULL;
                sa_mapping[o] <= '0;
            end
            sa_valid   <= '0;
            credit_err <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (out_gnt[o]) begin
                    rr_ptr[o] <= (out_win[o] == PTR_MAX) ? '0 : out_win[o] + PTR_ONE;
                end
                credit_cnt[o] <= cnt_next[o];
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                sa_mapping[i] <= grant[i] ? req_port[i] : '0;
            end
            sa_valid <= grant;
            if (|ovf) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - scoreboard bench for switch_allocator

module tb_switch_allocator;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_port [N];
    logic [N-1:0]  credit_in;
    logic [N-1:0]  grant;
    logic [N-1:0]  sa_mapping [N];
    logic [N-1:0]  sa_valid;
    logic [CW-1:0] credit_cnt [N];
    logic          credit_err;

    switch_allocator #(.NUM_PORTS(N), .BUF_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_port(req_port),
        .credit_in(credit_in), .grant(grant), .sa_mapping(sa_mapping),
        .sa_valid(sa_valid), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int         m_ptr [N];
    int         m_cnt [N];
    bit         m_err;
    logic [3:0] m_sav;
    logic [3:0] m_map [N];

    typedef struct {
        logic [3:0]  grant;
        logic [3:0]  sav;
        logic [15:0] map;
        logic [11:0] cnt;
        logic        err;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] pk(input logic [3:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [15:0] dut_map();
        return {sa_mapping[3], sa_mapping[2], sa_mapping[1], sa_mapping[0]};
    endfunction

    function automatic logic [11:0] dut_cnt();
        return {credit_cnt[3], credit_cnt[2], credit_cnt[1], credit_cnt[0]};
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_ptr[o] = 0;
            m_cnt[o] = D;
            m_map[o] = '0;
        end
        m_err = 0;
        m_sav = '0;
    endtask

    // Expected outputs for this cycle go into the scoreboard, then the model
    // advances to the state the next clock edge should produce.
    task automatic model_cycle(input logic [3:0] rv, input logic [15:0] rp, input logic [3:0] ci);
        int         win [N];
        logic [3:0] g;
        logic [3:0] p;
        exp_t       e;
        int         n;
        g = '0;
        for (int o = 0; o < N; o++) begin
            win[o] = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr[o] + k) % N;
                p = rp[i*4 +: 4];
                if (win[o] < 0 && rv[i] && $countones(p) == 1 && p[o] && m_cnt[o] > 0)
                    win[o] = i;
            end
            if (win[o] >= 0) g[win[o]] = 1'b1;
        end
        e.grant = g;
        e.sav   = m_sav;
        e.err   = m_err;
        for (int o = 0; o < N; o++) begin
            e.map[o*4 +: 4] = m_map[o];
            e.cnt[o*3 +: 3] = 3'(m_cnt[o]);
        end
        sb.push_back(e);
        for (int o = 0; o < N; o++) begin
            n = m_cnt[o] - ((win[o] >= 0) ? 1 : 0) + (ci[o] ? 1 : 0);
            if (n > D) begin
                n = D;
                m_err = 1;
            end
            m_cnt[o] = n;
            if (win[o] >= 0) m_ptr[o] = (win[o] + 1) % N;
        end
        m_sav = g;
        for (int i = 0; i < N; i++) m_map[i] = g[i] ? rp[i*4 +: 4] : 4'b0;
    endtask

    task automatic drive(input logic [3:0] rv, input logic [15:0] rp, input logic [3:0] ci);
        @(negedge clk);
        req_valid = rv;
        for (int i = 0; i < N; i++) req_port[i] = rp[i*4 +: 4];
        credit_in = ci;
        model_cycle(rv, rp, ci);
    endtask

    // Monitor: compares every cycle that has an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_grant", 32'(grant), 32'(e.grant));
                chk("sb_sa_valid", 32'(sa_valid), 32'(e.sav));
                chk("sb_sa_mapping", 32'(dut_map()), 32'(e.map));
                chk("sb_credit_cnt", 32'(dut_cnt()), 32'(e.cnt));
                chk("sb_credit_err", 32'(credit_err), 32'(e.err));
            end
        end
    end

    initial begin
        logic [3:0]  rv;
        logic [15:0] rp;
        logic [3:0]  ci;
        int          r;

        reset_n   = 1'b0;
        req_valid = '0;
        credit_in = '0;
        for (int i = 0; i < N; i++) req_port[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sa_valid", 32'(sa_valid), 0);
        chk("rst_sa_mapping", 32'(dut_map()), 0);
        chk("rst_grant", 32'(grant), 0);
        for (int o = 0; o < N; o++) chk("rst_credit_cnt", 32'(credit_cnt[o]), D);
        chk("rst_credit_err", 32'(credit_err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // All inputs contend for output 2: round-robin 0,1,2,3 then credits run out
        for (int c = 0; c < 4; c++) begin
            drive(4'hF, pk(4'h4, 4'h4, 4'h4, 4'h4), 4'h0);
            #3 chk("rr_grant_order", 32'(grant), 32'(1 << c));
        end
        drive(4'hF, pk(4'h4, 4'h4, 4'h4, 4'h4), 4'h0);
        #3 chk("no_credit_grant", 32'(grant), 0);
        chk("credit2_empty", 32'(credit_cnt[2]), 0);
        drive(4'hF, pk(4'h4, 4'h4, 4'h4, 4'h4), 4'h4);
        #3 chk("credit_not_same_cycle", 32'(grant), 0);
        drive(4'hF, pk(4'h4, 4'h4, 4'h4, 4'h4), 4'h0);
        #3 chk("credit_return_grant", 32'(grant), 32'b0001);
        repeat (4) drive(4'h0, 16'h0, 4'h4);

        // Distinct outputs: every input wins
        drive(4'hF, pk(4'h2, 4'h4, 4'h8, 4'h1), 4'h0);
        #3 chk("perm_grant", 32'(grant), 32'hF);
        drive(4'h0, 16'h0, 4'h0);
        #3 chk("perm_sa_valid", 32'(sa_valid), 32'hF);
        chk("perm_sa_mapping", 32'(dut_map()), 32'(pk(4'h2, 4'h4, 4'h8, 4'h1)));

        // Grant + return on output 1 cancel; overflow on output 3
        drive(4'h1, pk(4'h2, 4'h0, 4'h0, 4'h0), 4'h0);
        drive(4'h1, pk(4'h2, 4'h0, 4'h0, 4'h0), 4'h2);
        #3 chk("cancel_grant", 32'(grant), 32'b0001);
        drive(4'h0, 16'h0, 4'h8);
        #3 chk("cancel_cnt1", 32'(credit_cnt[1]), 2);
        drive(4'h0, 16'h0, 4'h8);
        drive(4'h0, 16'h0, 4'h0);
        #3 chk("ovf_cnt3", 32'(credit_cnt[3]), D);
        chk("ovf_err", 32'(credit_err), 1);

        // Malformed selects are ignored
        drive(4'h1, pk(4'h3, 4'h0, 4'h0, 4'h0), 4'h0);
        #3 chk("multihot_grant", 32'(grant), 0);
        drive(4'h1, pk(4'h0, 4'h0, 4'h0, 4'h0), 4'h0);
        #3 chk("zerohot_grant", 32'(grant), 0);
        drive(4'h0, 16'h0, 4'h0);
        #3;
        chk("bad_cnt0", 32'(credit_cnt[0]), 3);
        chk("bad_cnt1", 32'(credit_cnt[1]), 2);
        chk("bad_cnt2", 32'(credit_cnt[2]), 3);
        chk("bad_cnt3", 32'(credit_cnt[3]), 4);

        // Drain every output down to one credit, then reset with grants in flight
        for (int it = 0; it < 4; it++) begin
            rv = '0;
            rp = '0;
            for (int o = 0; o < N; o++) begin
                if (m_cnt[o] > 1) begin
                    rv[o] = 1'b1;
                    rp[o*4 +: 4] = 4'(1 << o);
                end
            end
            if (rv == '0) break;
            drive(rv, rp, 4'h0);
        end
        drive(4'hF, pk(4'h1, 4'h2, 4'h4, 4'h8), 4'h0);
        #3;
        for (int o = 0; o < N; o++) chk("pre_reset_cnt", 32'(credit_cnt[o]), 1);
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("async_sa_valid", 32'(sa_valid), 0);
        chk("async_sa_mapping", 32'(dut_map()), 0);
        chk("async_grant", 32'(grant), 0);
        for (int o = 0; o < N; o++) chk("async_cnt", 32'(credit_cnt[o]), D);
        chk("async_err", 32'(credit_err), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'hF, pk(4'h2, 4'h2, 4'h2, 4'h2), 4'h0);
        #3 chk("post_reset_grant", 32'(grant), 32'b0001);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                if (r < 8)       rp[i*4 +: 4] = 4'(1 << $urandom_range(0, 3));
                else if (r == 8) rp[i*4 +: 4] = 4'h0;
                else             rp[i*4 +: 4] = 4'($urandom_range(0, 15));
            end
            for (int o = 0; o < N; o++) ci[o] = ($urandom_range(0, 2) == 0);
            drive(rv, rp, ci);
        end
        drive(4'h0, 16'h0, 4'h0);
        repeat (2) @(negedge clk);
        #4;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
